mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have EX/MEM inputs: ex_valid 1; datatype TYPE_BITS; aluout DATA_BITS; dm_data DATA_BITS; pc2reg ADDR_BITS; rd_addr REG_BITS; reg_wr 1; rd_src 1; dm2reg 1; dm_rd 1; dm_wr 1.
REQ-004 SHALL have port mem_stall, output, 1: holds the EX/MEM producer; its inputs stay stable while mem_stall is high.
REQ-005 SHALL have data memory ports: dm_req out 1; dm_we out 1; dm_addr out ADDR_BITS, word-aligned; dm_wstrb out 4; dm_wdata out DATA_BITS; dm_ack in 1; dm_rdata in DATA_BITS.
REQ-006 SHALL have MEM/WB outputs: wb_valid 1; wb_rd_addr REG_BITS; wb_reg_wr 1; wb_data DATA_BITS.

Function
REQ-007 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-008 In IDLE with ex_valid=1 and dm_rd=dm_wr=0: SHALL register the result into the WB outputs at the next edge (1-cycle latency) with mem_stall=0.
REQ-009 Non-memory result SHALL be pc2reg when rd_src=1, else aluout.
REQ-010 In IDLE with ex_valid=1 and (dm_rd or dm_wr): SHALL drive mem_stall=1 combinationally and go to ACCESS.
REQ-011 In ACCESS: dm_req=1 SHALL be held, with address, strobes and data constant, until dm_ack=1; on dm_ack the FSM SHALL go to RESP.
REQ-012 dm_ack SHALL be ignored in IDLE and RESP.
REQ-013 In RESP: the WB outputs SHALL be registered, wb_valid=1 for exactly one cycle, mem_stall SHALL drop, and the FSM SHALL return to IDLE.
REQ-014 Loads (dm2reg=1): wb_data SHALL be dm_rdata shifted right by 8*aluout[1:0], then sign- or zero-extended per datatype (LB, LH, LW, LBU, LHU).
REQ-015 Stores: dm_wstrb SHALL be SB 4'b0001<<a[1:0], SH 4'b0011<<a[1:0], SW 4'b1111.
REQ-016 Stores: dm_wdata SHALL be dm_data shifted left by 8*a[1:0].
REQ-017 Stores SHALL produce wb_valid=1 with wb_reg_wr=0.
REQ-018 dm_wr=1 takes priority if dm_rd and dm_wr are both set; dm_we=dm_wr.
REQ-019 ex_valid=0 in IDLE: wb_valid=0 next cycle, no memory request.
REQ-020 Back-to-back memory ops: the second op SHALL be accepted in the cycle after RESP (IDLE); minimum 3 cycles per load/store with zero-wait dm_ack.

Reset
REQ-021 On rst=1 at a clock edge: FSM=IDLE; dm_req, dm_we, dm_wstrb, wb_valid, wb_reg_wr, mem_stall SHALL be 0; dm_addr, dm_wdata, wb_data, wb_rd_addr SHALL be 0.
REQ-022 Reset during ACCESS SHALL abandon the access; dm_req SHALL be 0 in the following cycle; a late dm_ack SHALL be ignored.

Configuration
REQ-023 Macro MEM_MISALIGN_EN: when defined, SHALL add output mem_misalign (1 bit, reset 0).
REQ-024 With MEM_MISALIGN_EN, a halfword access with a[0]=1, or a word access with a[1:0]!=0, SHALL issue no dm_req, SHALL pulse mem_misalign for 1 cycle, and SHALL produce wb_valid=1 with wb_reg_wr=0.
REQ-025 Without MEM_MISALIGN_EN: no misalignment check; a[1:0] SHALL be ignored for strobe and shift on word access and a[0] on half access.

Structure
REQ-026 Package mem_pkg SHALL hold the datatype encodings (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101, matching TYPE_BITS), the FSM state enum, and the strobe constants.
REQ-027 Sub-module load_align SHALL be combinational: dm_rdata, a[1:0], datatype -> extended data.

Verification
REQ-028 ALU op: aluout=32'h1234, rd_src=0, reg_wr=1, rd_addr=5 -> next cycle wb_valid=1, wb_data=32'h1234, wb_rd_addr=5, mem_stall=0.
REQ-029 LB at a=0x103, dm_rdata=32'h80FF_0000, ack after 2 wait cycles -> dm_addr=0x100, dm_req high 3 cycles, wb_data=32'hFFFF_FF80.
REQ-030 SH at a=0x102, dm_data=32'h0000_ABCD -> dm_wstrb=4'b1100, dm_wdata=32'hABCD_0000, wb_reg_wr=0.
REQ-031 LHU at a=0x2, dm_rdata=32'hBEEF_0000 -> wb_data=32'h0000_BEEF.
REQ-032 rst asserted mid-ACCESS, then dm_ack -> dm_req=0 and no wb_valid.
REQ-033 With MEM_MISALIGN_EN, LW at a=0x1 -> no dm_req, mem_misalign pulses once, wb_reg_wr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, datatype encodings, FSM states and strobe helpers for the memory stage
package mem_pkg;

  localparam int DATA_BITS = 32;
  localparam int ADDR_BITS = 32;
  localparam int REG_BITS  = 5;
  localparam int TYPE_BITS = 3;

  localparam logic [TYPE_BITS-1:0] LB  = 3'b000;
  localparam logic [TYPE_BITS-1:0] LH  = 3'b001;
  localparam logic [TYPE_BITS-1:0] LW  = 3'b010;
  localparam logic [TYPE_BITS-1:0] LBU = 3'b100;
  localparam logic [TYPE_BITS-1:0] LHU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Byte lane offset actually used: words ignore a[1:0], halves ignore a[0].
  function automatic logic [1:0] eff_off(input logic [TYPE_BITS-1:0] dt, input logic [1:0] a);
    case (dt)
      LB, LBU: return a;
      LH, LHU: return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [TYPE_BITS-1:0] dt, input logic [1:0] off);
    case (dt)
      LB, LBU: return STRB_B << off;
      LH, LHU: return STRB_H << off;
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [TYPE_BITS-1:0] dt, input logic [1:0] a);
    case (dt)
      LB, LBU: return 1'b0;
      LH, LHU: return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load data alignment and sign/zero extension
module load_align
  import mem_pkg::*;
(
  input  logic [DATA_BITS-1:0] i_rdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [TYPE_BITS-1:0] i_datatype,
  output logic [DATA_BITS-1:0] o_data
);

  logic [1:0]           w_off;
  logic [DATA_BITS-1:0] w_shift;

  always_comb begin
    w_off   = eff_off(i_datatype, i_addr_lo);
    w_shift = i_rdata >> {w_off, 3'b000};
    case (i_datatype)
      LB:      o_data = {{(DATA_BITS-8){w_shift[7]}}, w_shift[7:0]};
      LH:      o_data = {{(DATA_BITS-16){w_shift[15]}}, w_shift[15:0]};
      LBU:     o_data = {{(DATA_BITS-8){1'b0}}, w_shift[7:0]};
      LHU:     o_data = {{(DATA_BITS-16){1'b0}}, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - EX/MEM to MEM/WB controller with data memory handshake; MEM_MISALIGN_EN adds mem_misalign
module mem_stage_ctrl
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic [TYPE_BITS-1:0] datatype,
  input  logic [DATA_BITS-1:0] aluout,
  input  logic [DATA_BITS-1:0] dm_data,
  input  logic [ADDR_BITS-1:0] pc2reg,
  input  logic [REG_BITS-1:0]  rd_addr,
  input  logic                 reg_wr,
  input  logic                 rd_src,
  input  logic                 dm2reg,
  input  logic                 dm_rd,
  input  logic                 dm_wr,
  output logic                 mem_stall,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [3:0]           dm_wstrb,
  output logic [DATA_BITS-1:0] dm_wdata,
  input  logic                 dm_ack,
  input  logic [DATA_BITS-1:0] dm_rdata,
  output logic                 wb_valid,
  output logic [REG_BITS-1:0]  wb_rd_addr,
  output logic                 wb_reg_wr,
  output logic [DATA_BITS-1:0] wb_data
`ifdef MEM_MISALIGN_EN
  ,
  output logic                 mem_misalign
`endif
);

  state_e               r_state, w_next;
  logic                 w_mem_op, w_go;
  logic [1:0]           w_off;
  logic [DATA_BITS-1:0] w_load, w_res;

  logic                 r_we, r_dm2reg, r_reg_wr;
  logic [TYPE_BITS-1:0] r_dtype;
  logic [1:0]           r_alo;
  logic [REG_BITS-1:0]  r_rd_addr;
  logic [DATA_BITS-1:0] r_res, r_rdata, r_dm_wdata, r_wb_data;
  logic [ADDR_BITS-1:0] r_dm_addr;
  logic [3:0]           r_dm_wstrb;
  logic                 r_wb_valid, r_wb_reg_wr;
  logic [REG_BITS-1:0]  r_wb_rd_addr;

  assign w_mem_op = ex_valid & (dm_rd | dm_wr);
  assign w_off    = eff_off(datatype, aluout[1:0]);
  assign w_res    = rd_src ? pc2reg : aluout;
`ifdef MEM_MISALIGN_EN
  logic r_misalign;
  assign w_go         = w_mem_op & ~is_misaligned(datatype, aluout[1:0]);
  assign mem_misalign = r_misalign;
`else
  assign w_go = w_mem_op;
`endif

  load_align u_load_align (
    .i_rdata    (r_rdata),
    .i_addr_lo  (r_alo),
    .i_datatype (r_dtype),
    .o_data     (w_load)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_go) w_next = ST_ACCESS;
      ST_ACCESS: if (dm_ack) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = ((r_state == ST_IDLE) & w_go) | (r_state == ST_ACCESS);
    dm_req    = (r_state == ST_ACCESS);
    dm_we     = (r_state == ST_ACCESS) & r_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0; r_dm2reg <= 1'b0; r_reg_wr <= 1'b0; r_dtype <= '0; r_alo <= '0;
      r_rd_addr <= '0; r_res <= '0; r_rdata <= '0;
      r_dm_addr <= '0; r_dm_wstrb <= '0; r_dm_wdata <= '0;
      r_wb_valid <= 1'b0; r_wb_reg_wr <= 1'b0; r_wb_rd_addr <= '0; r_wb_data <= '0;
`ifdef MEM_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_we       <= dm_wr;
            r_dm2reg   <= dm2reg & ~dm_wr;
            r_reg_wr   <= reg_wr;
            r_dtype    <= datatype;
            r_alo      <= aluout[1:0];
            r_rd_addr  <= rd_addr;
            r_res      <= w_res;
            r_dm_addr  <= {aluout[ADDR_BITS-1:2], 2'b00};
            r_dm_wstrb <= dm_wr ? lane_strobe(datatype, w_off) : 4'b0000;
            r_dm_wdata <= dm_data << {w_off, 3'b000};
          end
`ifdef MEM_MISALIGN_EN
          else if (w_mem_op) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd_addr <= rd_addr;
            r_wb_reg_wr  <= 1'b0;
            r_wb_data    <= w_res;
            r_misalign   <= 1'b1;
          end
`endif
          else if (ex_valid) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd_addr <= rd_addr;
            r_wb_reg_wr  <= reg_wr;
            r_wb_data    <= w_res;
          end
        end
        ST_ACCESS: if (dm_ack) r_rdata <= dm_rdata;
        ST_RESP: begin
          r_wb_valid   <= 1'b1;
          r_wb_rd_addr <= r_rd_addr;
          r_wb_reg_wr  <= r_reg_wr & ~r_we;
          r_wb_data    <= r_dm2reg ? w_load : r_res;
        end
        default: ;
      endcase
    end
  end

  assign dm_addr    = r_dm_addr;
  assign dm_wstrb   = r_dm_wstrb;
  assign dm_wdata   = r_dm_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd_addr = r_wb_rd_addr;
  assign wb_reg_wr  = r_wb_reg_wr;
  assign wb_data    = r_wb_data;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed and randomized checks of mem_stage_ctrl against a byte-lane reference model
module tb_mem_stage_ctrl;

  localparam logic [2:0] T_LB = 3'b000, T_LH = 3'b001, T_LW = 3'b010, T_LBU = 3'b100, T_LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  datatype;
  logic [31:0] aluout, dm_data, pc2reg, dm_rdata, dm_addr, dm_wdata, wb_data;
  logic [4:0]  rd_addr, wb_rd_addr;
  logic        reg_wr, rd_src, dm2reg, dm_rd, dm_wr, mem_stall, dm_req, dm_we, dm_ack;
  logic [3:0]  dm_wstrb;
  logic        wb_valid, wb_reg_wr;
`ifdef MEM_MISALIGN_EN
  logic        mem_misalign;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .datatype(datatype), .aluout(aluout),
    .dm_data(dm_data), .pc2reg(pc2reg), .rd_addr(rd_addr), .reg_wr(reg_wr), .rd_src(rd_src),
    .dm2reg(dm2reg), .dm_rd(dm_rd), .dm_wr(dm_wr), .mem_stall(mem_stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_reg_wr(wb_reg_wr), .wb_data(wb_data)
`ifdef MEM_MISALIGN_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_size(input logic [2:0] dt);
    if (dt == T_LB || dt == T_LBU) return 1;
    if (dt == T_LH || dt == T_LHU) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [2:0] dt, input logic [31:0] a);
    int n = m_size(dt);
    return (a % 4) / n * n;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] dt, input logic [31:0] a, input logic [31:0] rd);
    int     n = m_size(dt);
    longint v = (longint'(rd) >> (8 * m_off(dt, a))) % (64'd1 << (8 * n));
    if ((dt == T_LB || dt == T_LH) && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strobe(input logic [2:0] dt, input logic [31:0] a);
    int s = ((1 << m_size(dt)) - 1) << m_off(dt, a);
    return s[3:0];
  endfunction

  task automatic alu_op(input logic [31:0] alu, input logic [31:0] pc, input logic src,
                        input logic [4:0] rd, input logic rw);
    ex_valid = 1'b1; dm_rd = 1'b0; dm_wr = 1'b0; dm2reg = 1'b0; datatype = 3'($urandom);
    aluout = alu; pc2reg = pc; rd_src = src; rd_addr = rd; reg_wr = rw; dm_ack = 1'($urandom);
    #1;
    chk("alu_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    dm_ack = 1'b0;
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_wb_data", wb_data, src ? pc : alu);
    chk("alu_wb_rd", {27'b0, wb_rd_addr}, {27'b0, rd});
    chk("alu_wb_reg_wr", {31'b0, wb_reg_wr}, {31'b0, rw});
    chk("alu_no_req", {31'b0, dm_req}, 32'd0);
  endtask

  task automatic idle_cycle();
    ex_valid = 1'b0; dm_ack = 1'($urandom);
    #1;
    chk("idle_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    dm_ack = 1'b0;
    chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("idle_no_req", {31'b0, dm_req}, 32'd0);
  endtask

  task automatic mem_op(input logic [2:0] dt, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdv, input int waits,
                        input logic [4:0] rd);
    int reqs = 0;
    ex_valid = 1'b1; datatype = dt; aluout = a; dm_data = wd; pc2reg = $urandom;
    rd_addr = rd; reg_wr = 1'b1; rd_src = 1'($urandom); dm_wr = wr; dm2reg = !wr;
    dm_rd = wr ? 1'($urandom) : 1'b1;
    #1;
    chk("mem_accept_stall", {31'b0, mem_stall}, 32'd1);
    chk("mem_accept_no_req", {31'b0, dm_req}, 32'd0);
    for (int w = 0; w <= waits; w++) begin
      tick();
      dm_ack = 1'b0;
      if (dm_req === 1'b1) reqs++;
      chk("acc_stall", {31'b0, mem_stall}, 32'd1);
      chk("acc_addr", dm_addr, {a[31:2], 2'b00});
      chk("acc_we", {31'b0, dm_we}, {31'b0, wr});
      if (wr) begin
        chk("acc_wstrb", {28'b0, dm_wstrb}, {28'b0, m_strobe(dt, a)});
        chk("acc_wdata", dm_wdata, wd << (8 * m_off(dt, a)));
      end
      if (w == waits) begin
        dm_ack = 1'b1; dm_rdata = rdv;
      end else begin
        dm_rdata = $urandom;
      end
    end
    tick();
    dm_ack = 1'b0; dm_rdata = $urandom;
    chk("req_cycles", reqs, waits + 1);
    chk("resp_no_req", {31'b0, dm_req}, 32'd0);
    chk("resp_stall", {31'b0, mem_stall}, 32'd0);
    chk("resp_wb_valid", {31'b0, wb_valid}, 32'd0);
    ex_valid = 1'b0;
    tick();
    chk("mem_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("mem_wb_rd", {27'b0, wb_rd_addr}, {27'b0, rd});
    chk("mem_wb_reg_wr", {31'b0, wb_reg_wr}, wr ? 32'd0 : 32'd1);
    if (!wr) chk("load_data", wb_data, m_load(dt, a, rdv));
  endtask

  initial begin
    logic [2:0] types [5];
    types[0] = T_LB; types[1] = T_LH; types[2] = T_LW; types[3] = T_LBU; types[4] = T_LHU;
    rst = 1'b1; ex_valid = 1'b0; datatype = '0; aluout = '0; dm_data = '0; pc2reg = '0;
    rd_addr = '0; reg_wr = 1'b0; rd_src = 1'b0; dm2reg = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0;
    tick(); tick();
    chk("rst_req", {31'b0, dm_req}, 32'd0);
    chk("rst_we", {31'b0, dm_we}, 32'd0);
    chk("rst_wstrb", {28'b0, dm_wstrb}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_reg_wr", {31'b0, wb_reg_wr}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd_addr}, 32'd0);
`ifdef MEM_MISALIGN_EN
    chk("rst_misalign", {31'b0, mem_misalign}, 32'd0);
`endif
    rst = 1'b0;

    alu_op(32'h1234, 32'hDEAD_0000, 1'b0, 5'd5, 1'b1);
    alu_op(32'h5555_0000, 32'h0000_0400, 1'b1, 5'd9, 1'b1);
    idle_cycle();
    mem_op(T_LB, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 2, 5'd3);
    mem_op(T_LH, 1'b1, 32'h102, 32'h0000_ABCD, 32'h0, 0, 5'd4);
    mem_op(T_LHU, 1'b0, 32'h2, 32'h0, 32'hBEEF_0000, 0, 5'd6);
    mem_op(T_LW, 1'b1, 32'h40, 32'hCAFE_F00D, 32'h0, 1, 5'd7);

    // reset while the access is outstanding, then a late ack
    ex_valid = 1'b1; datatype = T_LW; aluout = 32'h200; dm_rd = 1'b1; dm_wr = 1'b0; dm2reg = 1'b1;
    tick();
    chk("abort_req_before", {31'b0, dm_req}, 32'd1);
    rst = 1'b1; ex_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_req_after", {31'b0, dm_req}, 32'd0);
    chk("abort_stall", {31'b0, mem_stall}, 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    tick();
    dm_ack = 1'b0;
    chk("abort_late_ack_req", {31'b0, dm_req}, 32'd0);
    chk("abort_wb_valid", {31'b0, wb_valid}, 32'd0);
    tick();
    chk("abort_wb_valid2", {31'b0, wb_valid}, 32'd0);

`ifdef MEM_MISALIGN_EN
    ex_valid = 1'b1; datatype = T_LW; aluout = 32'h1; dm_rd = 1'b1; dm_wr = 1'b0; dm2reg = 1'b1;
    reg_wr = 1'b1; rd_addr = 5'd8;
    #1;
    chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("mis_pulse", {31'b0, mem_misalign}, 32'd1);
    chk("mis_no_req", {31'b0, dm_req}, 32'd0);
    chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("mis_wb_reg_wr", {31'b0, wb_reg_wr}, 32'd0);
    tick();
    chk("mis_pulse_end", {31'b0, mem_misalign}, 32'd0);
    chk("mis_no_req2", {31'b0, dm_req}, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      int          kind = $urandom_range(0, 3);
      logic [2:0]  dt   = types[$urandom_range(0, 4)];
      logic [31:0] a    = $urandom;
`ifdef MEM_MISALIGN_EN
      a = a & ~((m_size(dt) - 1) & 32'h3);
`endif
      case (kind)
        0: alu_op($urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom));
        1: mem_op(dt, 1'b0, a, $urandom, $urandom, $urandom_range(0, 3), 5'($urandom));
        2: mem_op((dt == T_LBU) ? T_LB : (dt == T_LHU) ? T_LH : dt, 1'b1, a, $urandom,
                  $urandom, $urandom_range(0, 3), 5'($urandom));
        default: idle_cycle();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
